// File: rtl/rv_load_generator.sv
// -----------------------------------------------------------------------------
// rv_load_generator
//
// Load-data formatter for the RISC-V memory-access / writeback path. Takes the
// raw word read from data memory plus the load funct3 and produces the sign- or
// zero-extended value destined for the register file.
//
// The formatted result (O_data) and the illegal-selector flag (O_illegal) are
// purely combinational, so the block can sit in the same cycle as the memory
// read. A one-stage registered copy is provided alongside for pipelines that
// want to break the path there.
//
// Handshake: I_valid is a valid-only qualifier with no ready/backpressure. A
// beat is taken on every rising I_clk edge where I_valid=1, one per cycle,
// unconditionally. O_valid_q is I_valid delayed by one cycle. O_data_q updates
// only on accepted beats and otherwise holds its last captured value.
//
// Parameters
//   USE_ADDR : 1 = byte/halfword lane chosen by I_addr.
//              0 = lane 0 is always used and I_addr is ignored.
//   XLEN     : data width. Only 32 is supported.
//
// Ports
//   I_clk            in   clock; all registers on the rising edge
//   I_rst_n          in   asynchronous active-low reset
//   I_valid          in   a load result is present this cycle
//   I_loadsel [2:0]  in   funct3: LB=000 LH=001 LW=010 LBU=100 LHU=101
//   I_addr    [1:0]  in   byte offset of the access (USE_ADDR=1 only)
//   I_data    [31:0] in   raw word from data memory
//   O_data    [31:0] out  combinational formatted result
//   O_data_q  [31:0] out  O_data registered on accepted beats
//   O_valid_q        out  I_valid registered
//   O_illegal        out  combinational: I_loadsel is not a legal load code
//   O_illegal_sticky out  set by a valid beat with an illegal selector; it is
//                         cleared only by reset
// -----------------------------------------------------------------------------
module rv_load_generator #(
  parameter int USE_ADDR = 0,
  parameter int XLEN     = 32
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  input  logic            I_valid,
  input  logic [2:0]      I_loadsel,
  input  logic [1:0]      I_addr,
  input  logic [XLEN-1:0] I_data,
  output logic [XLEN-1:0] O_data,
  output logic [XLEN-1:0] O_data_q,
  output logic            O_valid_q,
  output logic            O_illegal,
  output logic            O_illegal_sticky
);

  localparam logic [2:0] SEL_LB  = 3'b000;
  localparam logic [2:0] SEL_LH  = 3'b001;
  localparam logic [2:0] SEL_LW  = 3'b010;
  localparam logic [2:0] SEL_LBU = 3'b100;
  localparam logic [2:0] SEL_LHU = 3'b101;

  // Effective offset. When address steering is disabled, this is forced to
  // lane 0, so the rest of the logic has a single code path.
  logic [1:0]  addr_eff;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign addr_eff = (USE_ADDR != 0) ? I_addr : 2'b00;

  always_comb begin
    lane_byte = I_data[7:0];
    case (addr_eff)
      2'd0:    lane_byte = I_data[7:0];
      2'd1:    lane_byte = I_data[15:8];
      2'd2:    lane_byte = I_data[23:16];
      default: lane_byte = I_data[31:24];
    endcase
  end

  // Halfwords are assumed aligned. Only the upper offset bit picks the half.
  assign lane_half = addr_eff[1] ? I_data[31:16] : I_data[15:0];

  // Extension. An illegal selector falls back to passing the word through
  // unchanged (LW behaviour) and raises O_illegal.
  always_comb begin
    O_data    = I_data;
    O_illegal = 1'b0;
    case (I_loadsel)
      SEL_LB:  O_data = {{24{lane_byte[7]}}, lane_byte};
      SEL_LH:  O_data = {{16{lane_half[15]}}, lane_half};
      SEL_LW:  O_data = I_data;
      SEL_LBU: O_data = {24'h0, lane_byte};
      SEL_LHU: O_data = {16'h0, lane_half};
      default: begin
        O_data    = I_data;
        O_illegal = 1'b1;
      end
    endcase
  end

  // Registered stage. Reset asserted mid-stream discards whatever was pending.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_data_q         <= '0;
      O_valid_q        <= 1'b0;
      O_illegal_sticky <= 1'b0;
    end else begin
      O_valid_q <= I_valid;
      if (I_valid) begin
        O_data_q <= O_data;
      end
      O_illegal_sticky <= O_illegal_sticky | (I_valid & O_illegal);
    end
  end

endmodule

// File: tb/tb_rv_load_generator.sv
// -----------------------------------------------------------------------------
// tb_rv_load_generator
//
// Directed bench for rv_load_generator. Two instances share one set of inputs:
// u_dut0 with USE_ADDR=0 and u_dut1 with USE_ADDR=1. Inputs change on the
// falling edge, and outputs are sampled 1 ns after a clock edge.
// -----------------------------------------------------------------------------
module tb_rv_load_generator;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        valid;
  logic [2:0]  loadsel;
  logic [1:0]  addr;
  logic [31:0] data;

  logic [31:0] d0_data, d0_data_q, d1_data, d1_data_q;
  logic        d0_valid_q, d0_illegal, d0_sticky;
  logic        d1_valid_q, d1_illegal, d1_sticky;

  rv_load_generator #(.USE_ADDR(0), .XLEN(32)) u_dut0 (
    .I_clk(clk), .I_rst_n(rst_n), .I_valid(valid), .I_loadsel(loadsel),
    .I_addr(addr), .I_data(data), .O_data(d0_data), .O_data_q(d0_data_q),
    .O_valid_q(d0_valid_q), .O_illegal(d0_illegal), .O_illegal_sticky(d0_sticky)
  );

  rv_load_generator #(.USE_ADDR(1), .XLEN(32)) u_dut1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_valid(valid), .I_loadsel(loadsel),
    .I_addr(addr), .I_data(data), .O_data(d1_data), .O_data_q(d1_data_q),
    .O_valid_q(d1_valid_q), .O_illegal(d1_illegal), .O_illegal_sticky(d1_sticky)
  );

  // ---------------- checking ----------------
  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply one combinational vector on the falling edge, let it settle.
  task automatic drive(input logic [2:0] sel, input logic [1:0] a, input logic [31:0] d, input logic v);
    @(negedge clk);
    loadsel = sel;
    addr    = a;
    data    = d;
    valid   = v;
    #1;
  endtask

  task automatic after_posedge();
    @(posedge clk);
    #1;
  endtask

  // Five-selector sweep tables
  logic [2:0]  sweep_sel [5];
  logic [31:0] exp_80    [5];
  logic [31:0] exp_7f    [5];
  logic [31:0] exp_lb_a  [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    sweep_sel = '{LB, LH, LW, LBU, LHU};
    exp_80    = '{32'hffffff80, 32'hffff8080, 32'h80808080, 32'h00000080, 32'h00008080};
    exp_7f    = '{32'h0000007f, 32'h00007f7f, 32'h7f7f7f7f, 32'h0000007f, 32'h00007f7f};
    exp_lb_a  = '{32'h0000005d, 32'h0000006c, 32'h0000007b, 32'hffffff8a};

    rst_n   = 1'b0;
    valid   = 1'b0;
    loadsel = LW;
    addr    = 2'd0;
    data    = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst data_q",  d0_data_q, 32'h0);
    check("rst valid_q", {31'h0, d0_valid_q}, 32'h0);
    check("rst sticky",  {31'h0, d0_sticky}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep with sign bits set, lane 0
    for (int i = 0; i < 5; i++) begin
      drive(sweep_sel[i], 2'd0, 32'h80808080, 1'b0);
      check($sformatf("80 sel%0d data", i), d0_data, exp_80[i]);
      check($sformatf("80 sel%0d illegal", i), {31'h0, d0_illegal}, 32'h0);
    end

    // Positive values
    for (int i = 0; i < 5; i++) begin
      drive(sweep_sel[i], 2'd0, 32'h7f7f7f7f, 1'b0);
      check($sformatf("7f sel%0d data", i), d0_data, exp_7f[i]);
    end

    // Address steering
    for (int i = 0; i < 4; i++) begin
      drive(LB, i[1:0], 32'h8A7B6C5D, 1'b0);
      check($sformatf("lb addr%0d", i), d1_data, exp_lb_a[i]);
    end
    // USE_ADDR=0 ignores the offset
    check("noaddr lb addr3", d0_data, 32'h0000005d);
    drive(LHU, 2'd2, 32'h8A7B6C5D, 1'b0);
    check("lhu addr2", d1_data, 32'h00008a7b);
    drive(LH, 2'd2, 32'h8A7B6C5D, 1'b0);
    check("lh addr2", d1_data, 32'hffff8a7b);
    check("noaddr lh addr2", d0_data, 32'hffff8080 & 32'h0 | 32'h00006c5d);
    drive(LH, 2'd3, 32'h8A7B6C5D, 1'b0);
    check("lh addr3 half", d1_data, 32'hffff8a7b);
    drive(LW, 2'd3, 32'h8A7B6C5D, 1'b0);
    check("lw addr3", d1_data, 32'h8a7b6c5d);

    // Illegal selector
    drive(3'b111, 2'd0, 32'h12345678, 1'b1);
    check("ill data",   d0_data, 32'h12345678);
    check("ill flag",   {31'h0, d0_illegal}, 32'h1);
    check("ill sticky pre", {31'h0, d0_sticky}, 32'h0);
    after_posedge();
    check("ill sticky",  {31'h0, d0_sticky}, 32'h1);
    check("ill data_q",  d0_data_q, 32'h12345678);
    drive(LB, 2'd0, 32'h12345678, 1'b0);
    check("legal flag", {31'h0, d0_illegal}, 32'h0);
    after_posedge();
    check("sticky held", {31'h0, d0_sticky}, 32'h1);
    drive(3'b011, 2'd0, 32'h0, 1'b0);
    check("ill 011 flag", {31'h0, d1_illegal}, 32'h1);
    drive(3'b110, 2'd0, 32'h0, 1'b0);
    check("ill 110 flag", {31'h0, d1_illegal}, 32'h1);
    after_posedge();
    check("invalid no sticky", {31'h0, d1_sticky}, 32'h1);

    // Valid pulse then hold
    drive(LB, 2'd0, 32'h000000ff, 1'b1);
    after_posedge();
    check("pulse data_q",  d0_data_q, 32'hffffffff);
    check("pulse valid_q", {31'h0, d0_valid_q}, 32'h1);
    drive(LB, 2'd0, 32'h00000011, 1'b0);
    after_posedge();
    check("hold data_q",  d0_data_q, 32'hffffffff);
    check("hold valid_q", {31'h0, d0_valid_q}, 32'h0);

    // Asynchronous reset mid-cycle
    drive(LB, 2'd0, 32'h00000011, 1'b1);
    after_posedge();
    check("pre-rst data_q", d0_data_q, 32'h00000011);
    #1;
    rst_n = 1'b0;
    #1;
    check("async data_q",  d0_data_q, 32'h0);
    check("async valid_q", {31'h0, d0_valid_q}, 32'h0);
    check("async sticky",  {31'h0, d0_sticky}, 32'h0);
    check("rst comb data", d0_data, 32'h00000011);
    after_posedge();
    check("rst held data_q", d0_data_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    data  = 32'h00000080;
    after_posedge();
    check("post-rst data_q",  d0_data_q, 32'hffffff80);
    check("post-rst valid_q", {31'h0, d0_valid_q}, 32'h1);

    // Back-to-back beats
    drive(LBU, 2'd1, 32'h0000a500, 1'b1);
    after_posedge();
    check("b2b1 data_q", d1_data_q, 32'h000000a5);
    drive(LHU, 2'd2, 32'hbeef0000, 1'b1);
    after_posedge();
    check("b2b2 data_q", d1_data_q, 32'h0000beef);
    check("b2b2 valid_q", {31'h0, d1_valid_q}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
